// File: rtl/bm_arb_pkg.sv
// Shared definitions for the busmatrix round-robin arbiter.
//
// Contents:
//   arb_state_t      - arbiter state encoding (ARB_IDLE / ARB_OWN)
//   DEFAULT_NUM_REQ  - default number of slave-interface requesters
//   DEFAULT_MAX_HOLD - default completed-beat limit before forced re-arbitration
//   MAX_NUM_REQ      - largest requester count the helpers support
//   onehot_to_index  - converts a one-hot vector (up to 16 bits) to its index
package bm_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ  = 4;
    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int MAX_NUM_REQ      = 16;

    // OR-ing the index of every set bit gives the index directly for a
    // one-hot input, without building a priority chain.
    function automatic logic [3:0] onehot_to_index(input logic [MAX_NUM_REQ-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bm_rr_pick.sv
// Combinational round-robin winner selection.
//
// Ports:
//   req     in  NUM_REQ  request vector
//   last_id in  ID_W     index of the previous owner (lowest priority now)
//   winner  out ID_W     first requester at or above last_id+1, wrapping
//   found   out 1        at least one request is present
module bm_rr_pick
    import bm_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rotated;
    logic [NUM_REQ-1:0]   lowest;
    int                   start;
    int                   offset;
    int                   idx;

    // Duplicating req and shifting right by the start position rotates the
    // vector so bit 0 is the highest-priority requester. The lowest set bit
    // of the rotated vector is then the winner, offset back by start.
    always_comb begin
        start   = (int'(last_id) + 1) % NUM_REQ;
        req_dbl = {req, req};
        shifted = req_dbl >> start;
        rotated = shifted[NUM_REQ-1:0];
        lowest  = rotated & (-rotated);
        offset  = int'(onehot_to_index(MAX_NUM_REQ'(lowest)));
        idx     = (start + offset) % NUM_REQ;
        winner  = ID_W'(idx);
        found   = |req;
    end

endmodule

// File: rtl/bm_rr_arbiter.sv
// Round-robin arbiter sharing one busmatrix master interface between
// NUM_REQ slave-interface requesters, with a fairness hold limit.
//
// Ports:
//   hclk      in  1        clock, rising edge
//   hresetn   in  1        asynchronous active-low reset
//   req       in  NUM_REQ  per-requester request
//   lock      in  NUM_REQ  per-requester locked-sequence flag (owner only)
//   hreadyout in  1        target slave ready / beat complete
//   gnt       out NUM_REQ  registered one-hot grant
//   gnt_id    out ID_W     binary index of the owner, holds while idle
//   busy      out 1        OR of gnt
//   preempt   out 1        registered pulse in the cycle gnt drops on the hold limit
module bm_rr_arbiter
    import bm_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    input  logic               hreadyout,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               preempt
);

    // A zero MAX_HOLD disables pre-emption; keep a 1-bit counter so the
    // register never collapses to zero width.
    localparam int                 HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [NUM_REQ-1:0] ONE_BIT   = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    LAST_RST  = ID_W'(NUM_REQ - 1);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   pick_winner;
    logic              pick_found;
    logic              owner_req;
    logic              owner_lock;
    logic              others_pending;
    logic              at_limit;
    logic              do_preempt;

    bm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .winner  (pick_winner),
        .found   (pick_found)
    );

    assign owner_req      = req[gnt_id];
    assign owner_lock     = lock[gnt_id];
    assign others_pending = |(req & ~gnt);

    // The counter saturates at MAX_HOLD while a lock is held, so the limit
    // check uses >= to keep pre-emption armed until the lock drops.
    assign at_limit   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);
    assign do_preempt = at_limit && hreadyout && others_pending && !owner_lock;

    assign busy = |gnt;

    // Release takes precedence over pre-emption, so preempt only pulses when
    // the owner still wants the bus. Both exits park the pointer on the old
    // owner, which then has the lowest priority in the next arbitration.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            last_id  <= LAST_RST;
        end else begin
            preempt <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_found && hreadyout) begin
                        state    <= ARB_OWN;
                        gnt      <= ONE_BIT << pick_winner;
                        gnt_id   <= pick_winner;
                        hold_cnt <= '0;
                    end
                end
                ARB_OWN: begin
                    if (!owner_req) begin
                        state   <= ARB_IDLE;
                        gnt     <= '0;
                        last_id <= gnt_id;
                    end else if (do_preempt) begin
                        state   <= ARB_IDLE;
                        gnt     <= '0;
                        preempt <= 1'b1;
                        last_id <= gnt_id;
                    end else if (hreadyout && (hold_cnt != HOLD_SAT)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bm_rr_arbiter.sv
// Self-checking bench for bm_rr_arbiter (NUM_REQ=4, MAX_HOLD=4).
// A cycle-level model built from the arbitration rules is compared with the
// DUT on every falling edge; hand-computed checkpoints pin the model.
module tb_bm_rr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = 2;

    logic               hclk;
    logic               hresetn;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic               hreadyout;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               preempt;

    int vectors;
    int miscompares;

    bm_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD),
        .ID_W     (ID_W)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req       (req),
        .lock      (lock),
        .hreadyout (hreadyout),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .preempt   (preempt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: owner index (-1 when nobody owns), rotation pointer,
    // completed beats of the current owner, and the expected preempt pulse.
    int              m_owner;
    int              m_last;
    int              m_beats;
    int              m_gnt_id;
    logic            m_preempt;
    logic [NUM_REQ-1:0] m_gnt;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] owner_mask(input int owner);
        logic [NUM_REQ-1:0] m;
        m = '0;
        if (owner >= 0) m[owner] = 1'b1;
        return m;
    endfunction

    assign m_gnt = owner_mask(m_owner);

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_owner   <= -1;
            m_last    <= NUM_REQ - 1;
            m_beats   <= 0;
            m_gnt_id  <= 0;
            m_preempt <= 1'b0;
        end else begin
            m_preempt <= 1'b0;
            if (m_owner < 0) begin
                if (hreadyout && (req != '0)) begin
                    m_owner  <= rr_pick(req, m_last);
                    m_gnt_id <= rr_pick(req, m_last);
                    m_beats  <= 0;
                end
            end else if (!req[m_owner]) begin
                m_owner <= -1;
                m_last  <= m_owner;
            end else if (MAX_HOLD != 0 && hreadyout && (m_beats + 1 >= MAX_HOLD) &&
                         ((req & ~owner_mask(m_owner)) != '0) && !lock[m_owner]) begin
                m_owner   <= -1;
                m_last    <= m_owner;
                m_preempt <= 1'b1;
            end else if (hreadyout) begin
                m_beats <= m_beats + 1;
            end
        end
    end

    // Continuous comparison against the model away from the active edge.
    always @(negedge hclk) begin
        if (hresetn) begin
            vectors++;
            if (gnt !== m_gnt || gnt_id !== ID_W'(m_gnt_id) ||
                busy !== (m_gnt != '0) || preempt !== m_preempt) begin
                miscompares++;
                $display("[TB] FAIL model_cycle t=%0t: got gnt=%b id=%0d busy=%b preempt=%b, expected gnt=%b id=%0d busy=%b preempt=%b",
                         $time, gnt, gnt_id, busy, preempt, m_gnt, m_gnt_id, (m_gnt != '0), m_preempt);
            end
        end
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                                 input logic h);
        req       = r;
        lock      = l;
        hreadyout = h;
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic checkOutput(input string name, input logic [NUM_REQ-1:0] exp_gnt,
                               input logic exp_preempt);
        logic [ID_W-1:0] exp_id;
        logic            id_ok;
        exp_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_gnt[i]) exp_id = ID_W'(i);
        end
        id_ok = (exp_gnt == '0) || (gnt_id === exp_id);
        vectors++;
        if (gnt !== exp_gnt || preempt !== exp_preempt || busy !== (exp_gnt != '0) || !id_ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b preempt=%b, expected gnt=%b id=%0d busy=%b preempt=%b",
                     name, gnt, gnt_id, busy, preempt, exp_gnt, exp_id, (exp_gnt != '0), exp_preempt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hresetn     = 1'b0;
        req         = '0;
        lock        = '0;
        hreadyout   = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("reset_state", 4'b0000, 1'b0);
        if (gnt_id !== 2'd0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL reset_gnt_id: got %0d, expected 0", gnt_id);
        end else begin
            vectors++;
        end
        hresetn = 1'b1;

        $display("[TB] first arbitration after reset");
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("first_grant", 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("first_release", 4'b0000, 1'b0);

        $display("[TB] round-robin rotation");
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        checkOutput("rr_grant1", 4'b0010, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("rr_gap1", 4'b0000, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        checkOutput("rr_grant3", 4'b1000, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("rr_gap2", 4'b0000, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        checkOutput("rr_grant1_again", 4'b0010, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);

        $display("[TB] pre-emption at hold limit");
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkOutput("pre_hold_c1", 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0101, 4'b0000, 1'b1);
            checkOutput("pre_hold", 4'b0001, 1'b0);
        end
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        checkOutput("preempt_pulse", 4'b0000, 1'b1);
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        checkOutput("preempt_next_owner", 4'b0100, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);

        $display("[TB] lock and wait states");
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("lock_grant", 4'b0010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1011, 4'b0010, 1'b1);
            checkOutput("lock_hold", 4'b0010, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1011, 4'b0000, 1'b0);
            checkOutput("wait_state_hold", 4'b0010, 1'b0);
        end
        applyStimulus(4'b1011, 4'b0000, 1'b1);
        checkOutput("unlock_preempt", 4'b0000, 1'b1);
        applyStimulus(4'b1011, 4'b0000, 1'b1);
        checkOutput("unlock_next_owner", 4'b1000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);

        $display("[TB] idle with hreadyout low");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100, 4'b0000, 1'b0);
            checkOutput("idle_not_ready", 4'b0000, 1'b0);
        end
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        checkOutput("idle_ready_grant", 4'b0100, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);

        $display("[TB] asynchronous reset during ownership");
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("owner3_grant", 4'b1000, 1'b0);
        #2 hresetn = 1'b0;
        #1 checkOutput("async_reset_drop", 4'b0000, 1'b0);
        @(negedge hclk);
        hresetn = 1'b1;
        applyStimulus(4'b1001, 4'b0000, 1'b1);
        checkOutput("after_reset_grant", 4'b0001, 1'b0);

        $display("[TB] release while not ready");
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        checkOutput("not_ready_hold", 4'b0001, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("not_ready_release", 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("not_ready_idle", 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("sole_grant", 4'b1000, 1'b0);

        $display("[TB] sole requester past the limit");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b1000, 4'b0000, 1'b1);
            checkOutput("sole_no_preempt", 4'b1000, 1'b0);
        end
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkOutput("release_wins_over_preempt", 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("final_idle", 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bm_rr_arbiter.md
Name: bm_rr_arbiter

Overview:
- Round-robin arbiter for one busmatrix master interface.
- Shares that master interface between NUM_REQ slave-interface requesters.
- Enforces a fairness hold limit: ownership is pre-empted after MAX_HOLD completed beats when other requesters are waiting, unless the owner asserts lock.
- Drop-in replacement for the fixed-priority arbiter on a master interface; grant vector keeps the same one-hot meaning.

Parameters:
- NUM_REQ, 4, number of slave-interface requesters (2..16).
- MAX_HOLD, 16, completed beats before forced re-arbitration; 0 disables pre-emption.
- ID_W, $clog2(NUM_REQ), width of the encoded grant index.

Ports:
- hclk  in  1  clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high while the requester wants the master interface.
- lock  in  NUM_REQ  per-requester locked-sequence flag; sampled only for the current owner.
- hreadyout  in  1  HREADYOUT from the target AHB slave; high = beat completes / slave ready.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_id  out  ID_W  binary index of the owner; valid while busy.
- busy  out  1  OR of gnt.
- preempt  out  1  one-cycle pulse, registered, high in the cycle gnt drops due to the hold limit.

Behaviour:
- Reset (async, hresetn=0): gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0, last_id=NUM_REQ-1 (requester 0 wins the first arbitration), state=IDLE.
- Two states: IDLE and OWN.
- IDLE -> OWN: when |req & hreadyout.
  - Winner = first set req bit searching upward from last_id+1, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(winner), gnt_id=winner, hold_cnt=0.
  - Latency req->gnt = 1 cycle.
  - If hreadyout=0, stay IDLE with gnt=0.
- OWN, hold counting: hold_cnt increments on each cycle with hreadyout=1. It saturates at MAX_HOLD and is ID_W-independent, width $clog2(MAX_HOLD+1).
- OWN -> IDLE, release: when req[gnt_id]=0.
  - Next cycle gnt=0 and last_id=gnt_id.
  - There is always one dead cycle between owners; no zero-cycle handover.
- OWN -> IDLE, pre-emption: when all of the following hold:
  - MAX_HOLD!=0
  - hold_cnt==MAX_HOLD-1
  - hreadyout=1
  - (req & ~gnt)!=0
  - lock[gnt_id]=0
  - Next cycle: gnt=0, preempt=1, last_id=gnt_id.
  - The pre-empted requester keeps req high and re-competes at lowest rotating priority.
- Release and pre-emption true together: treat as release; preempt stays 0.
- lock high at the limit: no pre-emption. hold_cnt stays saturated. Pre-emption fires on the first cycle with lock low, hreadyout=1 and others pending.
- Only requester pending at the limit: no pre-emption; ownership continues.
- gnt never changes while hreadyout=0, except on release (req drop): an un-requested grant is dropped regardless of hreadyout.
- Requests changing while in OWN are ignored until return to IDLE.
- In IDLE, the winner is evaluated only in the cycle hreadyout=1.
- gnt is always one-hot or zero; gnt_id holds its last value while IDLE.
- Reset mid-ownership: gnt drops asynchronously; priority pointer returns to NUM_REQ-1.

Decomposition:
- Shared package bm_arb_pkg holds:
  - state encoding constants (ARB_IDLE=1'b0, ARB_OWN=1'b1)
  - default NUM_REQ and MAX_HOLD values
  - a onehot-to-index function
- One combinational sub-module, bm_rr_pick: inputs req and last_id; outputs winner index and a found flag. It uses a rotate / double-width priority encode.
- The FSM, counter and registers stay in bm_rr_arbiter.

Test Plan:
- Reset release, NUM_REQ=4, req=4'b1111, hreadyout=1 -> cycle+1 gnt=4'b0001, gnt_id=0.
- Round-robin rotation: req=4'b1010 constant, owners drop req for one cycle after 2 beats, then re-raise -> grant sequence 4'b0010, 4'b1000, 4'b0010, with one gnt=0 cycle between each.
- Pre-emption, MAX_HOLD=4: owner 0 holds req with lock=0, req[2]=1, hreadyout=1 -> gnt=4'b0001 for 4 cycles, then gnt=0 with preempt=1, then gnt=4'b0100.
- Lock and wait states, MAX_HOLD=4: owner 1 with lock[1]=1 for 10 beats, others pending -> no preempt. Then lock[1]=0 -> preempt on the next ready cycle. With hreadyout=0 for 3 cycles, hold_cnt freezes and gnt stays stable.
- hreadyout=0 in IDLE with req=4'b0100 -> gnt stays 0 until hreadyout=1, then gnt=4'b0100 one cycle later.
- Async reset asserted mid-OWN (gnt=4'b1000) -> gnt=0 immediately. After release with req=4'b1001, gnt=4'b0001.
